// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and helpers for the clock-enable generator
// Contents:
//   lock_state_t : global lock-emulation FSM states
//   clog2        : bits needed to represent values 0..value-1 (minimum 1)
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_LOCKING = 2'd1,
    ST_LOCKED  = 2'd2
  } lock_state_t;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        w = i + 1;
      end
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: counter, pending ratio, registered strobes
// Ports:
//   clk, rst        : system clock, synchronous active-low reset
//   i_div_val       : requested ratio (captured on i_div_load)
//   i_div_load      : one-cycle strobe, queues i_div_val until the next wrap
//   i_sync          : one-cycle strobe, forces phase 0 and applies any queued ratio
//   o_clk_en        : one-cycle enable, high once per divided period
//   o_clk_div       : registered divided square wave (data use only)
//   o_pend          : a queued ratio has not yet been applied
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] i_div_val,
  input  logic             i_div_load,
  input  logic             i_sync,
  output logic             o_clk_en,
  output logic             o_clk_div,
  output logic             o_pend
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_cur;
  logic [CNT_W-1:0] r_div_pend;
  logic             r_pend;
  logic             r_clk_en;
  logic             r_clk_div;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_div_pend_nxt;
  logic             w_pend_nxt;
  logic             w_bypass;
  logic             w_wrap;
  logic             w_bypass_nxt;
  logic             w_en_nxt;
  logic             w_sq_nxt;

  always_comb begin
    w_cnt_nxt      = r_cnt + ONE;
    w_div_nxt      = r_div_cur;
    w_div_pend_nxt = r_div_pend;
    w_pend_nxt     = r_pend;

    // Ratios 0 and 1 both mean "every cycle": the counter parks at 0 and
    // every edge counts as a wrap, so a queued ratio lands on the next edge.
    w_bypass = (r_div_cur <= ONE);
    w_wrap   = w_bypass || (r_cnt == (r_div_cur - ONE));

    if (i_sync) begin
      w_cnt_nxt  = '0;
      w_pend_nxt = 1'b0;
      if (i_div_load) begin
        w_div_nxt = i_div_val;
      end else if (r_pend) begin
        w_div_nxt = r_div_pend;
      end
    end else begin
      if (w_wrap) begin
        w_cnt_nxt = '0;
        // Ratio changes only at the wrap so the current period completes
        // cleanly and no runt pulse appears.
        if (r_pend) begin
          w_div_nxt  = r_div_pend;
          w_pend_nxt = 1'b0;
        end
      end
      // A load on the wrap edge itself is queued for the following wrap;
      // a later load simply overwrites the queued value.
      if (i_div_load) begin
        w_div_pend_nxt = i_div_val;
        w_pend_nxt     = 1'b1;
      end
    end

    // Outputs are derived from the next counter/ratio so they register in
    // step with the counter they describe.
    w_bypass_nxt = (w_div_nxt <= ONE);
    w_en_nxt     = w_bypass_nxt || (w_cnt_nxt == (w_div_nxt - ONE));
    w_sq_nxt     = !w_bypass_nxt && (w_cnt_nxt < (w_div_nxt >> 1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_div_cur  <= DIV_RST;
      r_div_pend <= DIV_RST;
      r_pend     <= 1'b0;
      r_clk_en   <= 1'b0;
      r_clk_div  <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_div_cur  <= w_div_nxt;
      r_div_pend <= w_div_pend_nxt;
      r_pend     <= w_pend_nxt;
      r_clk_en   <= w_en_nxt;
      r_clk_div  <= w_sq_nxt;
    end
  end

  assign o_clk_en  = r_clk_en;
  assign o_clk_div = r_clk_div;
  assign o_pend    = r_pend;

endmodule

// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - multi-channel programmable clock-enable generator with lock emulation
// Ports:
//   clk      : system clock, all logic on the rising edge
//   rst      : synchronous active-low reset
//   div_val  : per-channel ratio, channel i at [i*CNT_W +: CNT_W]
//   div_load : per-channel load strobe for div_val
//   sync     : realigns every channel to phase 0
//   clk_en   : per-channel single-cycle enable strobe
//   clk_div  : per-channel registered divided square wave
//   ready    : lock interval elapsed and no channel has a queued ratio
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*CNT_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       clk_en,
  output logic [NUM_CH-1:0]       clk_div,
  output logic                    ready
);

  localparam int               LCK_W    = clog2(LOCK_CYCLES + 1);
  localparam logic [LCK_W-1:0] LOCK_TGT = LCK_W'(LOCK_CYCLES);

  lock_state_t      r_state;
  lock_state_t      w_state_nxt;
  logic [LCK_W-1:0] r_lock_cnt;
  logic [LCK_W-1:0] w_lock_cnt_nxt;
  logic             w_locked;
  logic [NUM_CH-1:0] w_pend;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .i_div_val  (div_val[g*CNT_W +: CNT_W]),
      .i_div_load (div_load[g]),
      .i_sync     (sync),
      .o_clk_en   (clk_en[g]),
      .o_clk_div  (clk_div[g]),
      .o_pend     (w_pend[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_RESET;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  // r_lock_cnt holds the number of edges seen since reset release, so the
  // FSM is LOCKED right after edge LOCK_CYCLES.
  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    w_locked       = 1'b0;
    case (r_state)
      ST_RESET: begin
        w_lock_cnt_nxt = LCK_W'(1);
        w_state_nxt    = (w_lock_cnt_nxt == LOCK_TGT) ? ST_LOCKED : ST_LOCKING;
      end
      ST_LOCKING: begin
        w_lock_cnt_nxt = r_lock_cnt + LCK_W'(1);
        if (w_lock_cnt_nxt == LOCK_TGT) begin
          w_state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        w_locked = 1'b1;
      end
      default: begin
        w_state_nxt = ST_RESET;
      end
    endcase
  end

  assign ready = w_locked & ~(|w_pend);

endmodule
